lc3_regfile_sb: RTL and testbench

Scoreboarded, multi-port register file for the pipelined LC-3 datapath. It replaces the single-write, two-read register file with:
- a parametrised number of read ports;
- two write-back ports with fixed priority;
- optional write-to-read bypass;
- a per-register pending-write counter, so decode can detect RAW hazards and stall issue.

It sits between decode (reads, issue) and the execute/memory write-back stages.

---
 rtl/lc3_regfile_sb_pkg.sv | 22 ++
 rtl/lc3_regfile_sb_if.sv | 35 +++
 rtl/lc3_regfile_sb_pending_ctr.sv | 43 ++++
 rtl/lc3_regfile_sb.sv | 104 ++++++++++
 tb/tb_lc3_regfile_sb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_regfile_sb_pkg.sv
// Shared constants, read-source encoding and packed-port slicing helper
// for the scoreboarded LC-3 register file.
package lc3_rf_pkg;

  localparam int DEF_SEL_BITS   = 3;
  localparam int DEF_BIT_SIZE   = 16;
  localparam int DEF_CNT_BITS   = 2;
  localparam int DEF_READ_PORTS = 2;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_WB0 = 2'd1,
    SRC_WB1 = 2'd2
  } rd_src_e;

  // LSB of field `port` in a vector packing equal-width fields of `width` bits.
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/lc3_regfile_sb_if.sv
// Decode/write-back bus of the scoreboarded register file; master drives
// writes, selects and issue, slave returns read data and hazard status.
interface lc3_regfile_sb_if
  import lc3_rf_pkg::*;
#(
  parameter int SEL_BITS   = DEF_SEL_BITS,
  parameter int BIT_SIZE   = DEF_BIT_SIZE,
  parameter int READ_PORTS = DEF_READ_PORTS
) ();

  logic                           we0;
  logic [SEL_BITS-1:0]            DR0;
  logic [BIT_SIZE-1:0]            data0;
  logic                           we1;
  logic [SEL_BITS-1:0]            DR1;
  logic [BIT_SIZE-1:0]            data1;
  logic [READ_PORTS*SEL_BITS-1:0] sel_SR;
  logic [READ_PORTS*BIT_SIZE-1:0] SR;
  logic [READ_PORTS-1:0]          busy;
  logic                           issue_en;
  logic [SEL_BITS-1:0]            issue_DR;
  logic                           issue_ready;
  logic                           flush;

  modport master (
    output we0, DR0, data0, we1, DR1, data1, sel_SR, issue_en, issue_DR, flush,
    input  SR, busy, issue_ready
  );

  modport slave (
    input  we0, DR0, data0, we1, DR1, data1, sel_SR, issue_en, issue_DR, flush,
    output SR, busy, issue_ready
  );

endinterface

// File: rtl/lc3_regfile_sb_pending_ctr.sv
// Per-register pending-write counter: saturating up/down with two retire
// inputs and a synchronous clear.
module lc3_pending_ctr
  import lc3_rf_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_i,
  input  logic                dec0_i,
  input  logic                dec1_i,
  input  logic                clr_i,
  output logic [CNT_BITS-1:0] count_o,
  output logic                is_zero_o,
  output logic                is_max_o
);

  localparam int W = CNT_BITS + 2;
  localparam logic [W-1:0] MAX_W = W'((1 << CNT_BITS) - 1);

  logic [CNT_BITS-1:0] count_q, count_d;
  logic [W-1:0]        up, down, net;

  // Widened arithmetic so +1 and -2 never wrap before clamping.
  always_comb begin
    up   = W'(count_q) + W'(inc_i);
    down = W'(dec0_i) + W'(dec1_i);
    net  = (up > down) ? (up - down) : '0;
    if (net > MAX_W) net = MAX_W;
    count_d = clr_i ? '0 : net[CNT_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o   = count_q;
  assign is_zero_o = (count_q == '0);
  assign is_max_o  = (count_q == '1);

endmodule

// File: rtl/lc3_regfile_sb.sv
// Multi-read, dual-write-back LC-3 register file with optional write bypass
// and per-register pending-write scoreboard for RAW hazard detection.
module lc3_regfile_sb
  import lc3_rf_pkg::*;
#(
  parameter int SEL_BITS   = DEF_SEL_BITS,
  parameter int BIT_SIZE   = DEF_BIT_SIZE,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int CNT_BITS   = DEF_CNT_BITS,
  parameter int BYPASS     = 1
) (
  input logic             clk,
  input logic             reset,
  lc3_regfile_sb_if.slave bus
);

  localparam int unsigned TOTAL_REGS = 1 << SEL_BITS;

  logic [BIT_SIZE-1:0]   regs_q [TOTAL_REGS];
  logic [BIT_SIZE-1:0]   regs_d [TOTAL_REGS];
  logic [CNT_BITS-1:0]   count_w [TOTAL_REGS];
  logic [CNT_BITS:0]     ret_w [TOTAL_REGS];
  logic [TOTAL_REGS-1:0] is_zero_w, is_max_w, dec0_w, dec1_w, inc_w;
  logic                  issue_ok;

  logic [READ_PORTS*BIT_SIZE-1:0] sr_w;
  logic [READ_PORTS-1:0]          busy_w;

  // Port 1 is applied last so it wins a same-register collision.
  always_comb begin
    regs_d = regs_q;
    if (bus.we0) regs_d[bus.DR0] = bus.data0;
    if (bus.we1) regs_d[bus.DR1] = bus.data1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  for (genvar r = 0; r < TOTAL_REGS; r++) begin : g_reg
    assign dec0_w[r] = bus.we0 && (bus.DR0 == SEL_BITS'(r));
    assign dec1_w[r] = bus.we1 && (bus.DR1 == SEL_BITS'(r));
    assign inc_w[r]  = bus.issue_en && issue_ok && !bus.flush &&
                       (bus.issue_DR == SEL_BITS'(r));
    assign ret_w[r]  = (CNT_BITS+1)'(dec0_w[r]) + (CNT_BITS+1)'(dec1_w[r]);

    lc3_pending_ctr #(.CNT_BITS(CNT_BITS)) u_ctr (
      .clk       (clk),
      .rst_n     (reset),
      .inc_i     (inc_w[r]),
      .dec0_i    (dec0_w[r]),
      .dec1_i    (dec1_w[r]),
      .clr_i     (bus.flush),
      .count_o   (count_w[r]),
      .is_zero_o (is_zero_w[r]),
      .is_max_o  (is_max_w[r])
    );
  end

  // Depends on issue_DR only, never on issue_en.
  always_comb begin
    issue_ok = !is_max_w[bus.issue_DR];
    if ((BYPASS != 0) && (dec0_w[bus.issue_DR] || dec1_w[bus.issue_DR]))
      issue_ok = 1'b1;
    if (!reset) issue_ok = 1'b1;
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    localparam int unsigned SLSB = port_lsb(k, SEL_BITS);
    localparam int unsigned DLSB = port_lsb(k, BIT_SIZE);

    logic [SEL_BITS-1:0] sel;
    rd_src_e             src;
    logic [BIT_SIZE-1:0] rd;
    logic                bsy;

    assign sel = bus.sel_SR[SLSB +: SEL_BITS];

    always_comb begin
      src = SRC_REG;
      if (BYPASS != 0) begin
        if (dec1_w[sel])      src = SRC_WB1;
        else if (dec0_w[sel]) src = SRC_WB0;
      end
      unique case (src)
        SRC_WB1: rd = bus.data1;
        SRC_WB0: rd = bus.data0;
        default: rd = regs_q[sel];
      endcase
      // Bypassed busy: counter after this cycle's retires, before any issue.
      if (BYPASS != 0) bsy = ({1'b0, count_w[sel]} > ret_w[sel]);
      else             bsy = !is_zero_w[sel];
    end

    assign sr_w[DLSB +: BIT_SIZE] = reset ? rd : '0;
    assign busy_w[k]              = reset && bsy;
  end

  assign bus.SR          = sr_w;
  assign bus.busy        = busy_w;
  assign bus.issue_ready = issue_ok;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Directed scoreboard bench driving a bypassed and a non-bypassed instance
// with identical stimulus; expectations are queued and checked at negedge.
module tb_lc3_regfile_sb;
  import lc3_rf_pkg::*;

  localparam int SB = 3;
  localparam int BS = 16;
  localparam int RP = 2;
  localparam int CB = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lc3_regfile_sb_if #(.SEL_BITS(SB), .BIT_SIZE(BS), .READ_PORTS(RP)) ifb ();
  lc3_regfile_sb_if #(.SEL_BITS(SB), .BIT_SIZE(BS), .READ_PORTS(RP)) ifn ();

  assign ifn.we0      = ifb.we0;
  assign ifn.DR0      = ifb.DR0;
  assign ifn.data0    = ifb.data0;
  assign ifn.we1      = ifb.we1;
  assign ifn.DR1      = ifb.DR1;
  assign ifn.data1    = ifb.data1;
  assign ifn.sel_SR   = ifb.sel_SR;
  assign ifn.issue_en = ifb.issue_en;
  assign ifn.issue_DR = ifb.issue_DR;
  assign ifn.flush    = ifb.flush;

  lc3_regfile_sb #(.SEL_BITS(SB), .BIT_SIZE(BS), .READ_PORTS(RP),
                   .CNT_BITS(CB), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  lc3_regfile_sb #(.SEL_BITS(SB), .BIT_SIZE(BS), .READ_PORTS(RP),
                   .CNT_BITS(CB), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .bus(ifn)
  );

  typedef struct {
    string       name;
    bit          dut;   // 1 = bypassed instance
    int          port;
    logic [15:0] sr;
    logic        busy;
    logic        rdy;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    while (sbq.size() != 0) begin
      exp_t        e;
      logic [15:0] a_sr;
      logic        a_b, a_r;
      string       dn;
      e = sbq.pop_front();
      if (e.dut) begin
        a_sr = ifb.SR[e.port*BS +: BS]; a_b = ifb.busy[e.port]; a_r = ifb.issue_ready; dn = "byp";
      end else begin
        a_sr = ifn.SR[e.port*BS +: BS]; a_b = ifn.busy[e.port]; a_r = ifn.issue_ready; dn = "nob";
      end
      n_cmp += 3;
      if (a_sr !== e.sr) begin
        n_bad++;
        $display("FAIL %s/%s SR[%0d]: got %h expected %h", e.name, dn, e.port, a_sr, e.sr);
      end
      if (a_b !== e.busy) begin
        n_bad++;
        $display("FAIL %s/%s busy[%0d]: got %b expected %b", e.name, dn, e.port, a_b, e.busy);
      end
      if (a_r !== e.rdy) begin
        n_bad++;
        $display("FAIL %s/%s issue_ready: got %b expected %b", e.name, dn, a_r, e.rdy);
      end
    end
  end

  task automatic exp2(input string name, input int port,
                      input logic [15:0] sr_b, input logic busy_b, input logic rdy_b,
                      input logic [15:0] sr_n, input logic busy_n, input logic rdy_n);
    exp_t e;
    e.name = name; e.port = port;
    e.dut = 1'b1; e.sr = sr_b; e.busy = busy_b; e.rdy = rdy_b; sbq.push_back(e);
    e.dut = 1'b0; e.sr = sr_n; e.busy = busy_n; e.rdy = rdy_n; sbq.push_back(e);
  endtask

  task automatic idle();
    ifb.we0 = 1'b0; ifb.DR0 = '0; ifb.data0 = '0;
    ifb.we1 = 1'b0; ifb.DR1 = '0; ifb.data1 = '0;
    ifb.issue_en = 1'b0; ifb.issue_DR = '0; ifb.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sel(input logic [2:0] p0, input logic [2:0] p1);
    ifb.sel_SR = {p1, p0};
  endtask

  task automatic wr0(input logic [2:0] dr, input logic [15:0] d);
    ifb.we0 = 1'b1; ifb.DR0 = dr; ifb.data0 = d;
  endtask

  task automatic wr1(input logic [2:0] dr, input logic [15:0] d);
    ifb.we1 = 1'b1; ifb.DR1 = dr; ifb.data1 = d;
  endtask

  task automatic iss(input logic [2:0] dr);
    ifb.issue_en = 1'b1; ifb.issue_DR = dr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    // Held in reset: even a bypassed write must not show through.
    sel(3'd0, 3'd0); wr0(3'd0, 16'hFFFF);
    exp2("rst_hold", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step(); reset = 1'b1;
    exp2("rst_nowrite", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step();

    // Write R3, issue R3, then asynchronous reset mid-cycle.
    sel(3'd3, 3'd3); wr0(3'd3, 16'h1234);
    exp2("wr_r3", 0, 16'h1234, 0, 1, 16'h0000, 0, 1);
    step();
    iss(3'd3);
    exp2("r3_after", 1, 16'h1234, 0, 1, 16'h1234, 0, 1);
    step();
    exp2("r3_busy", 0, 16'h1234, 1, 1, 16'h1234, 1, 1);
    step();
    reset = 1'b0; ifb.issue_DR = 3'd3;
    exp2("rst_async_p0", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    exp2("rst_async_p1", 1, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step(); reset = 1'b1;
    exp2("rst_cleared", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step();

    // Collision on R5 with counter at 2.
    sel(3'd5, 3'd5); iss(3'd5);
    exp2("r5_iss1", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step();
    iss(3'd5);
    exp2("r5_iss2", 0, 16'h0000, 1, 1, 16'h0000, 1, 1);
    step();
    wr0(3'd5, 16'hAAAA); wr1(3'd5, 16'h5555);
    exp2("collide", 0, 16'h5555, 0, 1, 16'h0000, 1, 1);
    step();
    exp2("collide_after", 0, 16'h5555, 0, 1, 16'h5555, 0, 1);
    step();

    // Bypass of a write to R2.
    sel(3'd2, 3'd5); wr0(3'd2, 16'hBEEF);
    exp2("byp_r2", 0, 16'hBEEF, 0, 1, 16'h0000, 0, 1);
    exp2("byp_p1", 1, 16'h5555, 0, 1, 16'h5555, 0, 1);
    step();
    exp2("byp_next", 0, 16'hBEEF, 0, 1, 16'hBEEF, 0, 1);
    step();

    // Both ports to different registers.
    sel(3'd0, 3'd6); wr0(3'd0, 16'h1111); wr1(3'd6, 16'h6666);
    exp2("dual_p0", 0, 16'h1111, 0, 1, 16'h0000, 0, 1);
    exp2("dual_p1", 1, 16'h6666, 0, 1, 16'h0000, 0, 1);
    step();
    exp2("dual_p0_next", 0, 16'h1111, 0, 1, 16'h1111, 0, 1);
    exp2("dual_p1_next", 1, 16'h6666, 0, 1, 16'h6666, 0, 1);
    step();

    // Saturation of R7 (max 3 in flight).
    sel(3'd7, 3'd7); iss(3'd7);
    exp2("sat_iss1", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step();
    iss(3'd7);
    exp2("sat_iss2", 0, 16'h0000, 1, 1, 16'h0000, 1, 1);
    step();
    iss(3'd7);
    exp2("sat_iss3", 0, 16'h0000, 1, 1, 16'h0000, 1, 1);
    step();
    iss(3'd7);
    exp2("sat_full", 0, 16'h0000, 1, 0, 16'h0000, 1, 0);
    step();
    wr0(3'd7, 16'h0777); ifb.issue_DR = 3'd7;
    exp2("sat_ret1", 0, 16'h0777, 1, 1, 16'h0000, 1, 0);
    step();
    wr0(3'd7, 16'h0777); ifb.issue_DR = 3'd7;
    exp2("sat_ret2", 0, 16'h0777, 1, 1, 16'h0777, 1, 1);
    step();
    wr0(3'd7, 16'h0777); ifb.issue_DR = 3'd7;
    exp2("sat_ret3", 0, 16'h0777, 0, 1, 16'h0777, 1, 1);
    step();
    exp2("sat_clear", 0, 16'h0777, 0, 1, 16'h0777, 0, 1);
    step();

    // Issue and retire to R1 together, then flush with issue.
    sel(3'd1, 3'd6); iss(3'd1);
    exp2("r1_iss", 0, 16'h0000, 0, 1, 16'h0000, 0, 1);
    step();
    iss(3'd1); wr0(3'd1, 16'h0101);
    exp2("iss_ret", 0, 16'h0101, 0, 1, 16'h0000, 1, 1);
    step();
    exp2("iss_ret_after", 0, 16'h0101, 1, 1, 16'h0101, 1, 1);
    step();
    ifb.flush = 1'b1; iss(3'd6);
    exp2("flush_p0", 0, 16'h0101, 1, 1, 16'h0101, 1, 1);
    exp2("flush_p1", 1, 16'h6666, 0, 1, 16'h6666, 0, 1);
    step();
    exp2("flush_p0_after", 0, 16'h0101, 0, 1, 16'h0101, 0, 1);
    exp2("flush_p1_after", 1, 16'h6666, 0, 1, 16'h6666, 0, 1);
    step();

    // Retire to R4 with nothing pending must not wrap the counter.
    sel(3'd4, 3'd4); wr0(3'd4, 16'h4444);
    exp2("uflow_wr", 0, 16'h4444, 0, 1, 16'h0000, 0, 1);
    step();
    exp2("uflow_after", 0, 16'h4444, 0, 1, 16'h4444, 0, 1);
    step();
    iss(3'd4);
    exp2("uflow_iss", 0, 16'h4444, 0, 1, 16'h4444, 0, 1);
    step();
    wr0(3'd4, 16'h4445);
    exp2("uflow_ret", 0, 16'h4445, 0, 1, 16'h4444, 1, 1);
    step();
    exp2("uflow_done", 0, 16'h4445, 0, 1, 16'h4445, 0, 1);
    step();

    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation never checked by monitor", e.name);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
